// File: rtl/dshot_arm_controller.sv
// Turns the decoded DShot frame stream into a safe motor command: arming,
// link-loss/CRC failsafe, the settings-command repeat rule and beep/direction strobes.
module dshot_arm_controller #(
    parameter int ARM_FRAMES     = 10,
    parameter int TIMEOUT_CYCLES = 1600000,
    parameter int CMD_REPEAT     = 6,
    parameter int MAX_CRC_ERRORS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_valid,
    input  logic [10:0] set_speed,
    input  logic [5:0]  special_command,
    input  logic        is_special_command,
    input  logic        crc_valid,
    input  logic        telemetry_bit,
    output logic [10:0] throttle_out,
    output logic        throttle_update,
    output logic        armed,
    output logic        failsafe,
    output logic        cmd_strobe,
    output logic [5:0]  cmd_code,
    output logic        motor_reversed,
    output logic        telemetry_req,
    output logic [7:0]  crc_err_count
);

    localparam logic [1:0] S_DISARMED = 2'd0;
    localparam logic [1:0] S_ARMING   = 2'd1;
    localparam logic [1:0] S_ARMED    = 2'd2;
    localparam logic [1:0] S_FAILSAFE = 2'd3;

    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(CMD_REPEAT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0]   THR_MAX = 11'd1999;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic [7:0]    err_q, err_d, err_inc;
    logic [TW-1:0] to_q, to_d;
    logic [5:0]    rep_code_q, rep_code_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_next;
    logic [10:0]   thr_q, thr_d;
    logic          upd_q, upd_d;
    logic          stb_q, stb_d;
    logic [5:0]    code_q, code_d;
    logic          rev_q, rev_d;
    logic          tlm_q, tlm_d;
    logic [7:0]    crc_cnt_q, crc_cnt_d;

    logic good, bad, is_stop, is_thr, live, dir_code, beep_code;

    assign good      = frame_valid && crc_valid;
    assign bad       = frame_valid && !crc_valid;
    assign is_stop   = good && is_special_command && (special_command == 6'd0);
    assign is_thr    = good && !is_special_command;
    assign live      = (state_q == S_ARMING) || (state_q == S_ARMED);
    assign dir_code  = (special_command == 6'd7) || (special_command == 6'd8) ||
                       (special_command == 6'd20) || (special_command == 6'd21);
    assign beep_code = (special_command >= 6'd1) && (special_command <= 6'd5);

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        err_d      = err_q;
        to_d       = to_q;
        rep_code_d = rep_code_q;
        rep_cnt_d  = rep_cnt_q;
        rep_next   = rep_cnt_q;
        thr_d      = thr_q;
        upd_d      = 1'b0;
        stb_d      = 1'b0;
        code_d     = code_q;
        rev_d      = rev_q;
        tlm_d      = 1'b0;
        crc_cnt_d  = crc_cnt_q;
        err_inc    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

        if (bad) begin
            err_d     = err_inc;
            crc_cnt_d = (crc_cnt_q == 8'hFF) ? crc_cnt_q : crc_cnt_q + 8'd1;
            rep_cnt_d = '0;
        end
        if (good) begin
            err_d = '0;
            tlm_d = telemetry_bit;
        end

        if (live) begin
            if (good)
                to_d = '0;
            else if (to_q != TO_LAST)
                to_d = to_q + TW'(1);
        end else begin
            to_d = '0;
        end

        // Direction/settings commands fire only after CMD_REPEAT identical frames;
        // the count clears on firing even when the command is dropped.
        if (good && is_special_command) begin
            if (dir_code) begin
                rep_next   = (special_command == rep_code_q && rep_cnt_q != '0) ?
                             rep_cnt_q + RW'(1) : RW'(1);
                rep_code_d = special_command;
                if (rep_next == RW'(CMD_REPEAT)) begin
                    rep_cnt_d = '0;
                    if (state_q != S_FAILSAFE && thr_q == 11'd0) begin
                        stb_d  = 1'b1;
                        code_d = special_command;
                        rev_d  = (special_command == 6'd7) || (special_command == 6'd21);
                    end
                end else begin
                    rep_cnt_d = rep_next;
                end
            end else begin
                rep_cnt_d = '0;
                if (beep_code && state_q != S_FAILSAFE &&
                    (thr_q == 11'd0 || state_q == S_DISARMED)) begin
                    stb_d  = 1'b1;
                    code_d = special_command;
                end
            end
        end else if (good) begin
            rep_cnt_d = '0;
        end

        case (state_q)
            S_DISARMED: begin
                thr_d = 11'd0;
                if (is_stop) begin
                    state_d   = S_ARMING;
                    arm_cnt_d = AW'(1);
                end
            end
            S_ARMING: begin
                if (is_stop) begin
                    if (arm_cnt_q + AW'(1) == AW'(ARM_FRAMES)) begin
                        state_d   = S_ARMED;
                        arm_cnt_d = '0;
                        thr_d     = 11'd0;
                        upd_d     = 1'b1;
                    end else begin
                        arm_cnt_d = arm_cnt_q + AW'(1);
                    end
                end else if (good) begin
                    state_d   = S_DISARMED;
                    arm_cnt_d = '0;
                end
            end
            S_ARMED: begin
                if (is_thr) begin
                    thr_d = (set_speed > THR_MAX) ? THR_MAX : set_speed;
                    upd_d = 1'b1;
                end else if (is_stop) begin
                    thr_d = 11'd0;
                    upd_d = 1'b1;
                end
            end
            default: begin
                if (is_stop) begin
                    state_d   = S_ARMING;
                    arm_cnt_d = AW'(1);
                end
            end
        endcase

        // A good frame in the expiry cycle wins over the timeout.
        if (live && ((bad && err_inc >= 8'(MAX_CRC_ERRORS)) || (!good && to_q == TO_LAST))) begin
            state_d   = S_FAILSAFE;
            arm_cnt_d = '0;
            to_d      = '0;
            thr_d     = 11'd0;
            upd_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_DISARMED;
            arm_cnt_q  <= '0;
            err_q      <= '0;
            to_q       <= '0;
            rep_code_q <= '0;
            rep_cnt_q  <= '0;
            thr_q      <= '0;
            upd_q      <= 1'b0;
            stb_q      <= 1'b0;
            code_q     <= '0;
            rev_q      <= 1'b0;
            tlm_q      <= 1'b0;
            crc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            err_q      <= err_d;
            to_q       <= to_d;
            rep_code_q <= rep_code_d;
            rep_cnt_q  <= rep_cnt_d;
            thr_q      <= thr_d;
            upd_q      <= upd_d;
            stb_q      <= stb_d;
            code_q     <= code_d;
            rev_q      <= rev_d;
            tlm_q      <= tlm_d;
            crc_cnt_q  <= crc_cnt_d;
        end
    end

    assign throttle_out    = thr_q;
    assign throttle_update = upd_q;
    assign armed           = (state_q == S_ARMED);
    assign failsafe        = (state_q == S_FAILSAFE);
    assign cmd_strobe      = stb_q;
    assign cmd_code        = code_q;
    assign motor_reversed  = rev_q;
    assign telemetry_req   = tlm_q;
    assign crc_err_count   = crc_cnt_q;

endmodule

// File: tb/tb_dshot_arm_controller.sv
// Directed bench for dshot_arm_controller: a table of frames with hand-computed
// outputs, plus hand-written timeout and reset-during-arming sequences.
module tb_dshot_arm_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_valid;
    logic [10:0] set_speed;
    logic [5:0]  special_command;
    logic        is_special_command;
    logic        crc_valid;
    logic        telemetry_bit;
    logic [10:0] throttle_out;
    logic        throttle_update;
    logic        armed;
    logic        failsafe;
    logic        cmd_strobe;
    logic [5:0]  cmd_code;
    logic        motor_reversed;
    logic        telemetry_req;
    logic [7:0]  crc_err_count;

    int n_chk  = 0;
    int n_fail = 0;

    dshot_arm_controller #(
        .ARM_FRAMES(10), .TIMEOUT_CYCLES(1000), .CMD_REPEAT(6), .MAX_CRC_ERRORS(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid), .set_speed(set_speed),
        .special_command(special_command), .is_special_command(is_special_command),
        .crc_valid(crc_valid), .telemetry_bit(telemetry_bit), .throttle_out(throttle_out),
        .throttle_update(throttle_update), .armed(armed), .failsafe(failsafe),
        .cmd_strobe(cmd_strobe), .cmd_code(cmd_code), .motor_reversed(motor_reversed),
        .telemetry_req(telemetry_req), .crc_err_count(crc_err_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sp;
        logic [10:0] val;
        logic        crc;
        logic        tlm;
        logic        a;
        logic        f;
        logic [10:0] thr;
        logic        u;
        logic        s;
        logic [5:0]  code;
        logic        r;
        logic        t;
        logic [7:0]  cc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sp, input int val, input logic crc, input logic tlm,
                       input logic a, input logic f, input int thr, input logic u,
                       input logic s, input int code, input logic r, input logic t,
                       input int cc);
        vec_t v;
        v.sp = sp; v.val = val[10:0]; v.crc = crc; v.tlm = tlm;
        v.a = a; v.f = f; v.thr = thr[10:0]; v.u = u; v.s = s;
        v.code = code[5:0]; v.r = r; v.t = t; v.cc = cc[7:0];
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic a, input logic f,
                             input logic [10:0] thr, input logic u, input logic s,
                             input logic [5:0] code, input logic r, input logic t,
                             input logic [7:0] cc);
        chk({tag, ".armed"}, 32'(armed), 32'(a));
        chk({tag, ".failsafe"}, 32'(failsafe), 32'(f));
        chk({tag, ".throttle_out"}, 32'(throttle_out), 32'(thr));
        chk({tag, ".throttle_update"}, 32'(throttle_update), 32'(u));
        chk({tag, ".cmd_strobe"}, 32'(cmd_strobe), 32'(s));
        chk({tag, ".cmd_code"}, 32'(cmd_code), 32'(code));
        chk({tag, ".motor_reversed"}, 32'(motor_reversed), 32'(r));
        chk({tag, ".telemetry_req"}, 32'(telemetry_req), 32'(t));
        chk({tag, ".crc_err_count"}, 32'(crc_err_count), 32'(cc));
    endtask

    task automatic pulses_gone(input string tag);
        @(posedge clk); #1;
        chk({tag, ".upd_1cyc"}, 32'(throttle_update), 32'd0);
        chk({tag, ".stb_1cyc"}, 32'(cmd_strobe), 32'd0);
        chk({tag, ".tlm_1cyc"}, 32'(telemetry_req), 32'd0);
    endtask

    // Driver: one-cycle frame strobe, returns 1 ns after the edge that consumed it
    task automatic send(input logic sp, input logic [10:0] val, input logic crc, input logic tlm);
        @(posedge clk); #1;
        is_special_command = sp;
        set_speed          = val;
        special_command    = val[5:0];
        crc_valid          = crc;
        telemetry_bit      = tlm;
        frame_valid        = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic stop_frame(input string tag, input logic a, input logic u,
                              input logic [5:0] code, input logic [7:0] cc);
        send(1'b1, 11'd0, 1'b1, 1'b0);
        check_all(tag, a, 1'b0, 11'd0, u, 1'b0, code, 1'b0, 1'b0, cc);
        idle(98);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; frame_valid = 1'b0; set_speed = '0; special_command = '0;
        is_special_command = 1'b0; crc_valid = 1'b0; telemetry_bit = 1'b0;

        // Beep in DISARMED, then 9 stops only: throttle must not arm
        add(1, 3, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        for (int i = 1; i <= 9; i++) add(1, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        add(0, 1000, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        // Full arming, throttle with telemetry, bad frame with telemetry
        for (int i = 1; i <= 10; i++) add(1, 0, 1, 0, i == 10, 0, 0, i == 10, 0, 3, 0, 0, 0);
        add(0, 1000, 1, 1, 1, 0, 1000, 1, 0, 3, 0, 1, 0);
        add(0, 1000, 0, 1, 1, 0, 1000, 0, 0, 3, 0, 0, 1);
        add(0, 800, 1, 0, 1, 0, 800, 1, 0, 3, 0, 0, 1);
        // Three bad then good: stays armed; four bad: failsafe on the fourth
        for (int i = 1; i <= 3; i++) add(0, 800, 0, 0, 1, 0, 800, 0, 0, 3, 0, 0, 1 + i);
        add(0, 800, 1, 0, 1, 0, 800, 1, 0, 3, 0, 0, 4);
        for (int i = 1; i <= 4; i++)
            add(0, 800, 0, 0, i < 4, i == 4, (i == 4) ? 0 : 800, i == 4, 0, 3, 0, 0, 4 + i);
        for (int i = 1; i <= 10; i++) add(1, 0, 1, 0, i == 10, 0, 0, i == 10, 0, 3, 0, 0, 8);
        // Direction command repeat rule
        add(0, 0, 1, 0, 1, 0, 0, 1, 0, 3, 0, 0, 8);
        for (int i = 1; i <= 5; i++) add(1, 21, 1, 0, 1, 0, 0, 0, 0, 3, 0, 0, 8);
        add(0, 0, 1, 0, 1, 0, 0, 1, 0, 3, 0, 0, 8);
        for (int i = 1; i <= 6; i++)
            add(1, 21, 1, 0, 1, 0, 0, 0, i == 6, (i == 6) ? 21 : 3, i == 6, 0, 8);
        add(0, 300, 1, 0, 1, 0, 300, 1, 0, 21, 1, 0, 8);
        for (int i = 1; i <= 6; i++) add(1, 20, 1, 0, 1, 0, 300, 0, 0, 21, 1, 0, 8);
        add(1, 3, 1, 0, 1, 0, 300, 0, 0, 21, 1, 0, 8);
        add(1, 0, 1, 1, 1, 0, 0, 1, 0, 21, 1, 1, 8);
        add(1, 5, 1, 0, 1, 0, 0, 0, 1, 5, 1, 0, 8);
        for (int i = 1; i <= 6; i++)
            add(1, 8, 1, 0, 1, 0, 0, 0, i == 6, (i == 6) ? 8 : 5, i < 6, 0, 8);

        // Reset
        idle(3);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        idle(5);

        foreach (tbl[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            send(tbl[k].sp, tbl[k].val, tbl[k].crc, tbl[k].tlm);
            check_all(tag, tbl[k].a, tbl[k].f, tbl[k].thr, tbl[k].u, tbl[k].s,
                      tbl[k].code, tbl[k].r, tbl[k].t, tbl[k].cc);
            pulses_gone(tag);
            idle(97);
        end

        // Link-loss timeout: failsafe exactly 1000 cycles after the last good frame
        send(1'b0, 11'd1500, 1'b1, 1'b0);
        check_all("to_thr", 1, 0, 1500, 1, 0, 8, 0, 0, 8);
        n = 0;
        while (failsafe !== 1'b1 && n < 1200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd1000);
        check_all("timeout", 0, 1, 0, 1, 0, 8, 0, 0, 8);
        idle(50);

        // First stop clears failsafe; reset lands during the fifth arming frame
        for (int i = 1; i <= 4; i++) stop_frame($sformatf("fs_stop%0d", i), 0, 0, 8, 8);
        @(posedge clk); #1;
        is_special_command = 1'b1; special_command = 6'd0; crc_valid = 1'b1;
        telemetry_bit = 1'b1; frame_valid = 1'b1; reset_n = 1'b0;
        @(posedge clk); #1;
        frame_valid = 1'b0; reset_n = 1'b1; telemetry_bit = 1'b0;
        check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(98);
        for (int i = 1; i <= 10; i++)
            stop_frame($sformatf("rearm_stop%0d", i), i == 10, i == 10, 0, 0);
        send(1'b0, 11'd1000, 1'b1, 1'b0);
        check_all("rearm_thr", 1, 0, 1000, 1, 0, 0, 0, 0, 0);

        idle(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dshot_arm_controller.md
Name: dshot_arm_controller

Overview:
- Sequences the decoded DShot frame stream into a safe motor command.
- Sits between the DShot input decoder and the motor output stage; consumes one decoded frame per strobe.
- Enforces arming (consecutive stop frames), a link-loss failsafe timeout and a CRC-error failsafe.
- Applies the DShot repeat rule to settings commands, then forwards the throttle or issues a one-cycle command strobe.

Parameters:
ARM_FRAMES, 10, consecutive valid stop frames (special command 0) required to arm
TIMEOUT_CYCLES, 1600000, clk cycles without a CRC-valid frame before failsafe (100 ms at 16 MHz)
CMD_REPEAT, 6, consecutive identical frames required for commands 7, 8, 20, 21
MAX_CRC_ERRORS, 4, consecutive CRC-invalid frames that force failsafe

Ports:
clk  in  1  system clock (16 MHz)
reset_n  in  1  synchronous, active-low reset
frame_valid  in  1  one-cycle strobe: decoder outputs below hold a new frame
set_speed  in  11  decoded throttle, 0..1999, meaningful when is_special_command=0
special_command  in  6  decoded command, meaningful when is_special_command=1
is_special_command  in  1  frame is a command, not a throttle
crc_valid  in  1  frame CRC check passed
telemetry_bit  in  1  frame telemetry request bit
throttle_out  out  11  throttle to output stage, 0..1999
throttle_update  out  1  one-cycle pulse when throttle_out is (re)written
armed  out  1  high in ARMED state
failsafe  out  1  high in FAILSAFE state
cmd_strobe  out  1  one-cycle pulse: accepted command on cmd_code
cmd_code  out  6  last accepted special command
motor_reversed  out  1  spin-direction state; 0 = normal
telemetry_req  out  1  one-cycle pulse for accepted frames with telemetry_bit=1
crc_err_count  out  8  saturating total of CRC-invalid frames since reset

Behaviour:
- Reset (reset_n=0 on a clk edge): state DISARMED; all outputs 0; all counters 0. Reset mid-frame discards the frame.
- Only frames with frame_valid=1 are examined.
- Good frame: crc_valid=1. It clears the consecutive-error counter and the timeout counter.
- Bad frame: crc_valid=0. It increments the consecutive-error counter and crc_err_count (saturates at 255). It is otherwise ignored and does not reset the timeout.
- Stop frame: good frame with is_special_command=1 and special_command=0.
- Latency: every output responds on the clk edge after the frame_valid cycle (1 cycle). Pulses last exactly one cycle.
- States and transitions:
  - DISARMED: a stop frame moves to ARMING with arm_cnt=1. throttle_out is held at 0.
  - ARMING: a stop frame increments arm_cnt. When arm_cnt reaches ARM_FRAMES, go to ARMED; armed=1 and throttle_update pulses with 0. Any other good frame clears arm_cnt and returns to DISARMED. Bad frames leave arm_cnt unchanged.
  - ARMED: a good throttle frame loads throttle_out=set_speed and pulses throttle_update. A stop frame loads 0 and pulses throttle_update. Other commands go to the command filter and leave throttle_out unchanged.
  - FAILSAFE: failsafe=1, armed=0, throttle_out forced to 0 with one throttle_update pulse on entry. A stop frame moves to ARMING with arm_cnt=1; failsafe clears on that transition. Other frames are ignored.
- Failsafe entry from ARMING or ARMED on either condition:
  - timeout counter reaches TIMEOUT_CYCLES-1;
  - consecutive-error counter reaches MAX_CRC_ERRORS.
- The timeout counter runs only in ARMING and ARMED. It saturates and does not wrap.
- Simultaneous good frame and timeout expiry in the same cycle: the frame wins and the counter clears.
- Command filter (good command frames, nonzero code):
  - 1..5 (beep): accepted immediately with cmd_strobe, only if throttle_out==0 or state is DISARMED; otherwise dropped.
  - 7, 8, 20, 21: a repeat counter tracks the last code. A different code, a throttle frame or a bad frame restarts the count at 1 for the new code (0 for throttle or bad).
  - When the count reaches CMD_REPEAT: accept with cmd_strobe. Codes 7 and 21 set motor_reversed=1; codes 8 and 20 clear it. The counter then clears, so a further CMD_REPEAT repeats are needed to re-fire.
  - Accepted only if throttle_out==0.
  - All other codes are ignored.
- cmd_code updates only on cmd_strobe.
- telemetry_req pulses for any good frame with telemetry_bit=1, in any state.

Test Plan:
- Bench overrides: TIMEOUT_CYCLES=1000; frames spaced 100 cycles.
- Arming: reset, then 10 stop frames, then throttle 1000 -> armed rises 1 cycle after the 10th frame; throttle_out=1000 with throttle_update 1 cycle after the throttle frame. After only 9 stop frames, throttle 1000 -> remains DISARMED, throttle_out=0.
- Timeout: arm, throttle 1500, then no frames -> failsafe=1 and throttle_out=0 1000 cycles after the last good frame. Ten stop frames then re-arm; the first stop frame clears failsafe.
- CRC errors: armed at throttle 800, then 4 bad frames -> failsafe on the 4th, crc_err_count=4. Three bad frames then one good -> still ARMED, counter cleared.
- Direction command: armed at throttle 0, command 21 sent 5 times then throttle 0 -> no strobe. Command 21 sent 6 times -> cmd_strobe with cmd_code=21 and motor_reversed=1. Command 20 sent 6 times at throttle 300 -> dropped, motor_reversed stays 1.
- Beep plus reset: in DISARMED send command 3 -> cmd_strobe, cmd_code=3. Assert reset_n=0 for 1 cycle during the 5th arming frame -> all outputs 0 and a fresh 10 stop frames are needed.
- Telemetry: good throttle frame with telemetry_bit=1 -> telemetry_req pulses 1 cycle. Bad frame with telemetry_bit=1 -> no pulse.
